ahb_lite_sram_slave: RTL and testbench

AHB-Lite responder (slave end of the AHB_LITE_INTF bus) fronting a flop-based word memory.
Decodes address-phase controls and supports byte, halfword and word writes with lane enables.
Inserts a programmable number of wait states and returns the two-cycle ERROR response for illegal accesses.
Sits behind the system AHB-Lite decoder/mux as a scratchpad or register-bank target.

---
 rtl/ahb_lite_sram_slave.sv | 158 +++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder in front of a flop-based word memory with byte/half/word
// write lanes, programmable wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [2:0]            dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] WS = WAIT_STATES[1:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            lane_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept, legal, load, commit;
    logic size_bad, misaligned, range_bad;
    logic [3:0] be;
    state_t start_state;
    logic [1:0] start_cnt;

    // Handshake: an address phase is taken only when hsel, hready and a
    // NONSEQ/SEQ htrans coincide at a rising edge; the data phase completes on
    // the first cycle this slave drives hreadyout high.
    assign accept     = hsel & hready & htrans[1];
    assign size_bad   = hsize > 3'd2;
    assign misaligned = ((hsize == 3'd1) && haddr[0]) ||
                        ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign range_bad  = (haddr >> (IDX_W + 2)) != '0;
    assign legal      = !size_bad && !misaligned && !range_bad;

    // Where a completing/idle cycle goes next, given what is on the bus now.
    always_comb begin
        start_state = S_IDLE;
        start_cnt   = 2'd0;
        if (accept) begin
            if (!legal) begin
                start_state = S_ERR1;
            end else if (WS != 2'd0) begin
                start_state = S_WAIT;
                start_cnt   = WS;
            end else begin
                start_state = S_DATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE, S_ERR2: begin
                if (hready) begin
                    state_d = start_state;
                    cnt_d   = start_cnt;
                    load    = accept;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = S_DATA;
            end
            S_DATA: begin
                if (hready) begin
                    commit  = write_q;
                    state_d = start_state;
                    cnt_d   = start_cnt;
                    load    = accept;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be = 4'b0001 << lane_q;
            3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                idx_q   <= haddr[IDX_W+1:2];
                lane_q  <= haddr[1:0];
                size_q  <= hsize;
                write_q <= hwrite;
            end
        end
    end

    // Commit uses the registered data-phase controls, so it lands before the
    // next transfer's data phase and a following read sees the new word.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem[idx_q] : '0;
    assign dbg_state = state_q;

    logic unused_hprot;
    assign unused_hprot = ^hprot;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: three instances (0, 2 and 3 wait
// states) share one master; hready follows whichever instance is addressed.
module tb_ahb_lite_sram_slave;

    logic        hclk;
    logic        hreset_n;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_low;
    int          cur;

    logic        hsel0, hsel2, hsel3;
    logic        ro0, ro2, ro3;
    logic        rs0, rs2, rs3;
    logic [31:0] rd0, rd2, rd3;
    logic [2:0]  st0, st2, st3;

    int checks;
    int failures;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;

    assign hsel0  = hsel_bus && (cur == 0);
    assign hsel2  = hsel_bus && (cur == 2);
    assign hsel3  = hsel_bus && (cur == 3);
    assign hready = hready_low ? 1'b0 : (cur == 2) ? ro2 : (cur == 3) ? ro3 : ro0;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro0), .hresp(rs0),
        .hrdata(rd0), .dbg_state(st0)
    );

    ahb_lite_sram_slave #(.WAIT_STATES(2)) u_ws2 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel2), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro2), .hresp(rs2),
        .hrdata(rd2), .dbg_state(st2)
    );

    ahb_lite_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro3), .hresp(rs3),
        .hrdata(rd3), .dbg_state(st3)
    );

    // clock / reset
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        hsel_bus = 1'b1;
        haddr    = a;
        htrans   = T_NONSEQ;
        hwrite   = wr;
        hsize    = sz;
    endtask

    task automatic idle();
        hsel_bus = 1'b0;
        htrans   = T_IDLE;
        hwrite   = 1'b0;
        hsize    = 3'd0;
        haddr    = 32'h0;
    endtask

    // Single-cycle write on the zero-wait instance: address phase now, data next.
    task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        drive(a, 1'b1, sz);
        cyc();
        idle();
        hwdata = d;
        cyc();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cur        = 0;
        hready_low = 1'b0;
        hprot      = 4'h3;
        hwdata     = 32'h0;
        idle();
        hreset_n   = 1'b0;
        repeat (3) cyc();
        check("rst_hreadyout", {31'b0, ro0}, 32'h1);
        check("rst_hresp", {31'b0, rs0}, 32'h0);
        check("rst_hrdata", rd0, 32'h0);
        hreset_n = 1'b1;
        cyc();

        // read of 0x10 after reset
        drive(32'h10, 1'b0, 3'd2);
        cyc();
        idle();
        check("rst_read_ready", {31'b0, ro0}, 32'h1);
        check("rst_read_data", rd0, 32'h0);
        cyc();

        // word write then back-to-back read
        drive(32'h04, 1'b1, 3'd2);
        cyc();
        hwdata = 32'hDEADBEEF;
        drive(32'h04, 1'b0, 3'd2);
        check("wr_dphase_ready", {31'b0, ro0}, 32'h1);
        cyc();
        idle();
        check("b2b_ready", {31'b0, ro0}, 32'h1);
        check("b2b_resp", {31'b0, rs0}, 32'h0);
        check("b2b_data", rd0, 32'hDEADBEEF);
        cyc();
        check("idle_hrdata_zero", rd0, 32'h0);

        // byte and half lanes
        wr0(32'h08, 3'd2, 32'h00000000);
        wr0(32'h09, 3'd0, 32'h0000AA00);
        wr0(32'h0A, 3'd1, 32'h12340000);
        drive(32'h08, 1'b0, 3'd2);
        cyc();
        idle();
        check("lanes_08", rd0, 32'h1234AA00);
        cyc();
        wr0(32'h0C, 3'd2, 32'hFFFFFFFF);
        wr0(32'h0C, 3'd0, 32'hAAAAAA55);
        wr0(32'h0E, 3'd1, 32'h9876BBBB);
        drive(32'h0C, 1'b0, 3'd2);
        cyc();
        idle();
        check("lanes_0c", rd0, 32'h9876FF55);
        cyc();

        // hready low from another slave: no accept
        hready_low = 1'b1;
        drive(32'h04, 1'b0, 3'd2);
        cyc();
        idle();
        hready_low = 1'b0;
        check("hready_low_no_accept", rd0, 32'h0);
        cyc();

        // errors: misaligned word, out of range, bad size
        drive(32'h02, 1'b1, 3'd2);
        cyc();
        idle();
        hwdata = 32'hBADBAD00;
        check("err1_ready", {31'b0, ro0}, 32'h0);
        check("err1_resp", {31'b0, rs0}, 32'h1);
        cyc();
        check("err2_ready", {31'b0, ro0}, 32'h1);
        check("err2_resp", {31'b0, rs0}, 32'h1);
        drive(32'h400, 1'b1, 3'd2);
        cyc();
        idle();
        hwdata = 32'h5A5A5A5A;
        check("range_err1", {30'b0, ro0, rs0}, 32'h1);
        cyc();
        check("range_err2", {30'b0, ro0, rs0}, 32'h3);
        drive(32'h00, 1'b0, 3'd2);
        cyc();
        idle();
        check("after_err_ok", {30'b0, ro0, rs0}, 32'h2);
        check("err_mem_unchanged", rd0, 32'h0);
        cyc();
        drive(32'h10, 1'b0, 3'd3);
        cyc();
        idle();
        check("size_err1", {30'b0, ro0, rs0}, 32'h1);
        cyc();
        check("size_err2", {30'b0, ro0, rs0}, 32'h3);
        cyc();
        check("err_cancel_idle", {30'b0, ro0, rs0}, 32'h2);

        // two wait states
        cur = 2;
        drive(32'h20, 1'b1, 3'd2);
        cyc();
        idle();
        hwdata = 32'hCAFE0001;
        check("ws2_wr_w1", {31'b0, ro2}, 32'h0);
        cyc();
        check("ws2_wr_w2", {31'b0, ro2}, 32'h0);
        cyc();
        check("ws2_wr_done", {31'b0, ro2}, 32'h1);
        drive(32'h20, 1'b0, 3'd2);
        cyc();
        idle();
        check("ws2_rd_w1", {31'b0, ro2}, 32'h0);
        check("ws2_rd_w1_data", rd2, 32'h0);
        cyc();
        check("ws2_rd_w2", {31'b0, ro2}, 32'h0);
        check("ws2_rd_w2_data", rd2, 32'h0);
        cyc();
        check("ws2_rd_done", {30'b0, ro2, rs2}, 32'h2);
        check("ws2_rd_data", rd2, 32'hCAFE0001);
        cyc();

        // reset during WAIT with three wait states
        cur = 3;
        drive(32'h0C, 1'b1, 3'd2);
        cyc();
        idle();
        hwdata = 32'h00000055;
        check("ws3_w1", {31'b0, ro3}, 32'h0);
        cyc();
        check("ws3_w2", {31'b0, ro3}, 32'h0);
        hreset_n = 1'b0;
        #1;
        check("async_rst_ready", {31'b0, ro3}, 32'h1);
        check("async_rst_resp", {31'b0, rs3}, 32'h0);
        check("async_rst_data", rd3, 32'h0);
        cyc();
        hreset_n = 1'b1;
        cyc();
        drive(32'h0C, 1'b0, 3'd2);
        cyc();
        idle();
        check("ws3_rd_w1", {31'b0, ro3}, 32'h0);
        cyc();
        check("ws3_rd_w2", {31'b0, ro3}, 32'h0);
        cyc();
        check("ws3_rd_w3", {31'b0, ro3}, 32'h0);
        cyc();
        check("ws3_rd_done", {30'b0, ro3, rs3}, 32'h2);
        check("ws3_lost_write", rd3, 32'h0);
        cyc();

        // reset also cleared the zero-wait instance's memory
        cur = 0;
        drive(32'h04, 1'b0, 3'd2);
        cyc();
        idle();
        check("rst_cleared_mem", rd0, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
